// File: rtl/prod_table_mp_pkg.sv
// Shared types and sizing for the multi-lane producer table.
// Latency: n/a (types only); backpressure: n/a.
package prod_table_mp_pkg;

    localparam int REG_FILE_SIZE = 32;
    localparam int NUM_REGS      = REG_FILE_SIZE;
    localparam int ROB_SIZE      = 4;
    localparam int ISSUE_W       = 2;
    localparam int WB_W          = 2;
    localparam int AW            = $clog2(NUM_REGS);
    localparam int CW            = AW + 1;
    localparam int NUM_SRC       = ISSUE_W * 2;

    typedef logic [ROB_SIZE-1:0] tag_t;
    typedef logic [AW-1:0]       addr_t;
    typedef logic [CW-1:0]       cnt_t;

    typedef struct packed {
        logic ready;
        tag_t tag;
    } prod_entry_t;

    // Low bit of element idx in a flat vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/prod_table_mp_if.sv
// Dispatch-side bundle of the producer table: issue, writeback, flush and source reads.
// Latency: reads combinational, updates one cycle; backpressure: stall_i gates issue only.
interface prod_table_mp_if;
    import prod_table_mp_pkg::*;

    logic                         stall_i;
    logic                         flush_i;
    logic [ISSUE_W-1:0]           iss_en_i;
    logic [ISSUE_W*AW-1:0]        iss_rd_i;
    logic [ISSUE_W*ROB_SIZE-1:0]  iss_tag_i;
    logic [NUM_SRC*AW-1:0]        src_addr_i;
    logic [NUM_SRC-1:0]           src_ready_o;
    logic [NUM_SRC*ROB_SIZE-1:0]  src_tag_o;
    logic [WB_W-1:0]              wb_en_i;
    logic [WB_W*AW-1:0]           wb_dest_i;
    logic [WB_W*ROB_SIZE-1:0]     wb_tag_i;
    logic [CW-1:0]                pending_cnt_o;

    modport master (
        output stall_i, flush_i, iss_en_i, iss_rd_i, iss_tag_i, src_addr_i,
               wb_en_i, wb_dest_i, wb_tag_i,
        input  src_ready_o, src_tag_o, pending_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, iss_en_i, iss_rd_i, iss_tag_i, src_addr_i,
               wb_en_i, wb_dest_i, wb_tag_i,
        output src_ready_o, src_tag_o, pending_cnt_o
    );

endinterface

// File: rtl/prod_table_mp_src_lookup.sv
// One source-operand read path: table entry, then wb bypass, then older-lane forwarding, then r0.
// Latency: combinational; backpressure: none (forwarding deliberately ignores stall).
module prod_src_lookup
    import prod_table_mp_pkg::*;
#(
    parameter int LANE = 0
) (
    input  addr_t                       src_addr_i,
    input  prod_entry_t                 ent_i,
    input  logic [WB_W-1:0]             wb_en_i,
    input  logic [WB_W*AW-1:0]          wb_dest_i,
    input  logic [WB_W*ROB_SIZE-1:0]    wb_tag_i,
    input  logic [ISSUE_W-1:0]          iss_en_i,
    input  logic [ISSUE_W*AW-1:0]       iss_rd_i,
    input  logic [ISSUE_W*ROB_SIZE-1:0] iss_tag_i,
    output logic                        ready_o,
    output tag_t                        tag_o
);

    logic rdy;
    tag_t tg;

    always_comb begin
        rdy = ent_i.ready;
        tg  = ent_i.tag;
        for (int j = 0; j < WB_W; j++) begin
            if (wb_en_i[j] && wb_dest_i[slice_lo(j, AW) +: AW] == src_addr_i &&
                wb_tag_i[slice_lo(j, ROB_SIZE) +: ROB_SIZE] == ent_i.tag) begin
                rdy = 1'b1;
                tg  = '0;
            end
        end
        // Ascending scan so the youngest older lane overrides.
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k < LANE && iss_en_i[k] && src_addr_i != '0 &&
                iss_rd_i[slice_lo(k, AW) +: AW] == src_addr_i) begin
                rdy = 1'b0;
                tg  = iss_tag_i[slice_lo(k, ROB_SIZE) +: ROB_SIZE];
            end
        end
        if (src_addr_i == '0) begin
            rdy = 1'b1;
        end
        ready_o = rdy;
        tag_o   = rdy ? '0 : tg;
    end

endmodule

// File: rtl/prod_table_mp.sv
// Per-register ready/tag table with multi-lane issue, writeback, flush and pending count.
// Latency: reads combinational, updates one cycle; backpressure: stall_i blocks issue, not writeback.
module prod_table_mp
    import prod_table_mp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    prod_table_mp_if.slave tbl_if
);

    prod_entry_t tab_q [NUM_REGS];
    prod_entry_t tab_d [NUM_REGS];
    cnt_t        cnt_q;
    cnt_t        cnt_d;

    logic [NUM_SRC-1:0]          src_rdy;
    logic [NUM_SRC*ROB_SIZE-1:0] src_tag;

    always_comb begin
        tab_d = tab_q;
        cnt_d = '0;
        if (tbl_if.flush_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tab_d[r] = '{ready: 1'b1, tag: '0};
            end
        end else begin
            for (int j = 0; j < WB_W; j++) begin
                if (tbl_if.wb_en_i[j] &&
                    !tab_q[tbl_if.wb_dest_i[slice_lo(j, AW) +: AW]].ready &&
                    tab_q[tbl_if.wb_dest_i[slice_lo(j, AW) +: AW]].tag ==
                        tbl_if.wb_tag_i[slice_lo(j, ROB_SIZE) +: ROB_SIZE]) begin
                    tab_d[tbl_if.wb_dest_i[slice_lo(j, AW) +: AW]].ready = 1'b1;
                end
            end
            // Issue applied after writeback so it wins; later lanes overwrite earlier ones.
            if (!tbl_if.stall_i) begin
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (tbl_if.iss_en_i[i] && tbl_if.iss_rd_i[slice_lo(i, AW) +: AW] != '0) begin
                        tab_d[tbl_if.iss_rd_i[slice_lo(i, AW) +: AW]] =
                            '{ready: 1'b0,
                              tag:   tbl_if.iss_tag_i[slice_lo(i, ROB_SIZE) +: ROB_SIZE]};
                    end
                end
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + cnt_t'(!tab_d[r].ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                tab_q[r] <= '{ready: 1'b1, tag: '0};
            end
            cnt_q <= '0;
        end else begin
            tab_q <= tab_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        prod_src_lookup #(.LANE(g / 2)) u_lookup (
            .src_addr_i (tbl_if.src_addr_i[slice_lo(g, AW) +: AW]),
            .ent_i      (tab_q[tbl_if.src_addr_i[slice_lo(g, AW) +: AW]]),
            .wb_en_i    (tbl_if.wb_en_i),
            .wb_dest_i  (tbl_if.wb_dest_i),
            .wb_tag_i   (tbl_if.wb_tag_i),
            .iss_en_i   (tbl_if.iss_en_i),
            .iss_rd_i   (tbl_if.iss_rd_i),
            .iss_tag_i  (tbl_if.iss_tag_i),
            .ready_o    (src_rdy[g]),
            .tag_o      (src_tag[slice_lo(g, ROB_SIZE) +: ROB_SIZE])
        );
    end

    assign tbl_if.src_ready_o   = src_rdy;
    assign tbl_if.src_tag_o     = src_tag;
    assign tbl_if.pending_cnt_o = cnt_q;

endmodule

// File: tb/tb_prod_table_mp.sv
// Bench for prod_table_mp: directed scenarios then random traffic against a register-level model.
module tb_prod_table_mp;
    import prod_table_mp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prod_table_mp_if bus_if ();

    prod_table_mp dut (
        .clk    (clk),
        .rst    (rst),
        .tbl_if (bus_if)
    );

    int n_chk = 0;
    int n_bad = 0;

    bit m_rdy [NUM_REGS];
    int m_tag [NUM_REGS];

    bit st, fl;
    bit ie [ISSUE_W];
    int ird [ISSUE_W];
    int itg [ISSUE_W];
    int sa [ISSUE_W][2];
    bit we [WB_W];
    int wd [WB_W];
    int wt [WB_W];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        st = 0;
        fl = 0;
        for (int i = 0; i < ISSUE_W; i++) begin
            ie[i] = 0; ird[i] = 0; itg[i] = 0; sa[i][0] = 0; sa[i][1] = 0;
        end
        for (int j = 0; j < WB_W; j++) begin
            we[j] = 0; wd[j] = 0; wt[j] = 0;
        end
    endtask

    task automatic drive();
        bus_if.stall_i = st;
        bus_if.flush_i = fl;
        for (int i = 0; i < ISSUE_W; i++) begin
            bus_if.iss_en_i[i]                        = ie[i];
            bus_if.iss_rd_i[i*AW +: AW]               = AW'(ird[i]);
            bus_if.iss_tag_i[i*ROB_SIZE +: ROB_SIZE]  = ROB_SIZE'(itg[i]);
            for (int s = 0; s < 2; s++) begin
                bus_if.src_addr_i[(i*2+s)*AW +: AW] = AW'(sa[i][s]);
            end
        end
        for (int j = 0; j < WB_W; j++) begin
            bus_if.wb_en_i[j]                        = we[j];
            bus_if.wb_dest_i[j*AW +: AW]             = AW'(wd[j]);
            bus_if.wb_tag_i[j*ROB_SIZE +: ROB_SIZE]  = ROB_SIZE'(wt[j]);
        end
    endtask

    function automatic logic dut_rdy(input int l, input int s);
        return bus_if.src_ready_o[l*2+s];
    endfunction

    function automatic logic [31:0] dut_tag(input int l, input int s);
        return 32'(bus_if.src_tag_o[(l*2+s)*ROB_SIZE +: ROB_SIZE]);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_rdy[r] = 1;
            m_tag[r] = 0;
        end
    endtask

    function automatic int model_pending();
        int c = 0;
        for (int r = 0; r < NUM_REGS; r++) if (!m_rdy[r]) c++;
        return c;
    endfunction

    // Expected view of one source this cycle, rules applied in order of increasing priority.
    task automatic exp_src(input int l, input int s, output bit r, output int t);
        int a = sa[l][s];
        r = m_rdy[a];
        t = m_tag[a];
        for (int j = 0; j < WB_W; j++)
            if (we[j] && wd[j] == a && wt[j] == m_tag[a]) begin r = 1; t = 0; end
        for (int k = 0; k < l; k++)
            if (ie[k] && ird[k] == a && a != 0) begin r = 0; t = itg[k]; end
        if (a == 0) begin r = 1; t = 0; end
        if (r) t = 0;
    endtask

    task automatic model_step();
        bit nr [NUM_REGS];
        int nt [NUM_REGS];
        if (fl) begin
            model_reset();
        end else begin
            nr = m_rdy;
            nt = m_tag;
            for (int j = 0; j < WB_W; j++)
                if (we[j] && !m_rdy[wd[j]] && m_tag[wd[j]] == wt[j]) nr[wd[j]] = 1;
            if (!st)
                for (int i = 0; i < ISSUE_W; i++)
                    if (ie[i] && ird[i] != 0) begin nr[ird[i]] = 0; nt[ird[i]] = itg[i]; end
            m_rdy = nr;
            m_tag = nt;
        end
    endtask

    task automatic check_all(input string nm);
        bit r;
        int t;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int s = 0; s < 2; s++) begin
                exp_src(l, s, r, t);
                check($sformatf("%s.l%0ds%0d.rdy", nm, l, s), 32'(dut_rdy(l, s)), 32'(r));
                check($sformatf("%s.l%0ds%0d.tag", nm, l, s), dut_tag(l, s), 32'(t));
            end
        end
        check($sformatf("%s.cnt", nm), 32'(bus_if.pending_cnt_o), 32'(model_pending()));
    endtask

    task automatic begin_cyc(input string nm);
        drive();
        @(negedge clk);
        check_all(nm);
    endtask

    task automatic end_cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm);
        begin_cyc(nm);
        end_cyc();
    endtask

    initial begin
        int p;
        model_reset();
        idle();
        drive();
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        idle(); sa[0][0] = 5;
        begin_cyc("t1");
        check("t1.r5.rdy", 32'(dut_rdy(0, 0)), 32'd1);
        check("t1.pend", 32'(bus_if.pending_cnt_o), 32'd0);
        end_cyc();

        // Intra-bundle forwarding, then table visibility.
        idle(); ie[0] = 1; ird[0] = 3; itg[0] = 7; sa[1][0] = 3;
        begin_cyc("t2a");
        check("t2a.fwd.rdy", 32'(dut_rdy(1, 0)), 32'd0);
        check("t2a.fwd.tag", dut_tag(1, 0), 32'd7);
        end_cyc();
        idle(); sa[0][0] = 3;
        begin_cyc("t2b");
        check("t2b.r3.tag", dut_tag(0, 0), 32'd7);
        check("t2b.pend", 32'(bus_if.pending_cnt_o), 32'd1);
        end_cyc();

        // Same-rd lanes: youngest wins; stale wb ignored; matching wb bypasses.
        idle(); ie[0] = 1; ie[1] = 1; ird[0] = 4; ird[1] = 4; itg[0] = 2; itg[1] = 5;
        cyc("t3a");
        idle(); we[0] = 1; wd[0] = 4; wt[0] = 2; sa[0][0] = 4;
        begin_cyc("t3b");
        check("t3b.r4.tag", dut_tag(0, 0), 32'd5);
        end_cyc();
        idle(); we[1] = 1; wd[1] = 4; wt[1] = 5; sa[0][1] = 4;
        begin_cyc("t3c");
        check("t3c.byp.rdy", 32'(dut_rdy(0, 1)), 32'd1);
        end_cyc();
        idle(); sa[1][1] = 4;
        cyc("t3d");

        // Issue beats writeback unless stalled.
        idle(); ie[0] = 1; ird[0] = 6; itg[0] = 1;
        cyc("t4a");
        idle(); we[0] = 1; wd[0] = 6; wt[0] = 1; ie[0] = 1; ird[0] = 6; itg[0] = 9;
        cyc("t4b");
        idle(); sa[0][0] = 6;
        begin_cyc("t4c");
        check("t4c.r6.tag", dut_tag(0, 0), 32'd9);
        end_cyc();
        idle(); st = 1; we[0] = 1; wd[0] = 6; wt[0] = 9; ie[0] = 1; ird[0] = 6; itg[0] = 12;
        cyc("t4d");
        idle(); sa[0][0] = 6;
        begin_cyc("t4e");
        check("t4e.r6.rdy", 32'(dut_rdy(0, 0)), 32'd1);
        end_cyc();

        // r0 stays ready.
        idle(); ie[0] = 1; ird[0] = 0; itg[0] = 3;
        cyc("t5a");
        idle(); ie[0] = 1; ird[0] = 0; itg[0] = 3; sa[1][0] = 0;
        begin_cyc("t5b");
        check("t5b.r0.rdy", 32'(dut_rdy(1, 0)), 32'd1);
        end_cyc();

        // Fill r1..r10, then flush alongside an issue.
        for (int n = 0; n < 5; n++) begin
            idle(); ie[0] = 1; ie[1] = 1;
            ird[0] = 2*n + 1; ird[1] = 2*n + 2; itg[0] = n; itg[1] = n + 8;
            cyc("t6fill");
        end
        idle();
        begin_cyc("t6a");
        check("t6a.pend", 32'(bus_if.pending_cnt_o), 32'd10);
        end_cyc();
        idle(); fl = 1; ie[0] = 1; ird[0] = 11; itg[0] = 4;
        cyc("t6b");
        idle(); sa[0][0] = 11;
        begin_cyc("t6c");
        check("t6c.pend", 32'(bus_if.pending_cnt_o), 32'd0);
        end_cyc();

        // Random traffic on a narrow register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(15) == 0);
            for (int i = 0; i < ISSUE_W; i++) begin
                ie[i]  = 1'($urandom_range(1));
                ird[i] = $urandom_range(11);
                itg[i] = $urandom_range(15);
                sa[i][0] = $urandom_range(11);
                sa[i][1] = $urandom_range(11);
            end
            for (int j = 0; j < WB_W; j++) begin
                we[j] = 1'($urandom_range(1));
                wd[j] = $urandom_range(11);
                wt[j] = ($urandom_range(1) != 0) ? m_tag[wd[j]] : $urandom_range(15);
            end
            cyc("rnd");
        end

        // Make sure something is pending, then reset between edges.
        idle(); ie[0] = 1; ird[0] = 9; itg[0] = 13;
        cyc("pre_rst");
        idle();
        p = 9;
        sa[0][0] = p;
        drive();
        #2 rst = 1'b1;
        #1;
        check("async.rdy", 32'(dut_rdy(0, 0)), 32'd1);
        check("async.tag", dut_tag(0, 0), 32'd0);
        check("async.pend", 32'(bus_if.pending_cnt_o), 32'd0);
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
